// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg: shared types and helpers for the FIFO write arbiter.
// Package fifo_arb_pkg (no ports):
//   MAX_NREQ         - largest supported requester count
//   fifo_arb_state_e - lock FSM state (used when FIFO_ARB_LOCK_EN is defined)
//   id_width(nreq)   - tag width, clog2 with a minimum of 1
package fifo_arb_pkg;

    localparam int MAX_NREQ = 16;

    typedef enum logic {
        IDLE,
        LOCKED
    } fifo_arb_state_e;

    function automatic int id_width(input int nreq);
        return (nreq > 2) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester handshake plus FIFO write-port bundle.
// Signals:
//   req_valid[NREQ], req_data[NREQ*DSIZE], req_last[NREQ] - requester side
//   req_ready[NREQ]                                       - accept strobe
//   fifo_din[IDW+DSIZE], fifo_wr_en                       - to FIFO din/wr_en
//   fifo_full                                             - from FIFO full
// Modports: master (requesters/FIFO model), slave (the arbiter).
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8
);
    localparam int IDW = id_width(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic [IDW+DSIZE-1:0]  fifo_din;
    logic                  fifo_wr_en;
    logic                  fifo_full;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_din, fifo_wr_en
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_din, fifo_wr_en
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker (rotate, find-first, rotate back).
// Ports:
//   req[NREQ]      - request vector
//   ptr[IDW]       - highest-priority index, must be < NREQ
//   grant_id[IDW]  - first requesting index at or after ptr, wrapping at NREQ
//   any            - at least one request present
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDW-1:0]    off;
    logic [IDW:0]      sum;

    always_comb begin
        // bit j of rot is req[(ptr+j) mod NREQ]
        dbl = {req, req} >> ptr;
        rot = dbl[NREQ-1:0];
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (rot[i]) off = IDW'(i);
        // rotate back, wrapping at NREQ rather than 2^IDW
        sum      = {1'b0, ptr} + {1'b0, off};
        grant_id = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : sum[IDW-1:0];
        any      = |req;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one sync_fifo write port among NREQ requesters.
// Ports:
//   clk   - rising-edge clock
//   rst_b - asynchronous active-low reset
//   bus   - fifo_wr_arbiter_if.slave: requester valid/ready/data/last, FIFO din/wr_en/full
// Each accepted beat is tagged {id, data} and passes through a one-entry registered stage.
// Optional macro FIFO_ARB_LOCK_EN: holds the grant on one requester until its req_last beat.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NREQ  = 4,
    parameter int  DSIZE = 8,
    localparam int IDW   = id_width(NREQ)
) (
    input  logic             clk,
    input  logic             rst_b,
    fifo_wr_arbiter_if.slave bus
);

    if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
        $error("fifo_wr_arbiter: NREQ out of range");
    end

    logic [IDW-1:0]       ptr_q, ptr_d;
    logic                 out_valid_q, out_valid_d;
    logic [IDW+DSIZE-1:0] out_data_q, out_data_d;
    logic [IDW-1:0]       pick_id, grant, next_ptr;
    logic                 pick_any;
    logic                 out_accept, transfer, advance;
    logic [NREQ-1:0]      ready;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req      (bus.req_valid),
        .ptr      (ptr_q),
        .grant_id (pick_id),
        .any      (pick_any)
    );

`ifdef FIFO_ARB_LOCK_EN
    fifo_arb_state_e state_q, state_d;
    logic [IDW-1:0]  lock_id_q, lock_id_d;
    logic            locked;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
        end
    end

    // while locked the grant already equals lock_id, so recording grant is safe in both states
    always_comb begin
        state_d   = transfer ? (bus.req_last[grant] ? IDLE : LOCKED) : state_q;
        lock_id_d = transfer ? grant : lock_id_q;
    end

    always_comb begin
        locked  = state_q == LOCKED;
        grant   = locked ? lock_id_q : pick_id;
        advance = transfer & bus.req_last[grant];
    end
`else
    logic unused_last;

    assign unused_last = ^bus.req_last;
    assign grant       = pick_id;
    assign advance     = transfer;
`endif

    always_comb begin
        out_accept   = ~out_valid_q | ~bus.fifo_full;
        ready        = '0;
        // gating on the granted requester's own valid also covers a locked but idle owner
        ready[grant] = rst_b & out_accept & pick_any & bus.req_valid[grant];
        transfer     = ready[grant];
        next_ptr     = (32'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
        ptr_d        = advance ? next_ptr : ptr_q;
        out_valid_d  = transfer | (out_valid_q & bus.fifo_full);
        out_data_d   = transfer ? {grant, bus.req_data[grant*DSIZE +: DSIZE]} : out_data_q;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.fifo_wr_en = out_valid_q;
    assign bus.fifo_din   = out_data_q;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of a `sync_fifo` among NREQ independent requesters. Each requester presents data on a valid/ready handshake. The block picks one requester per cycle, tags the beat with the requester index, and writes `{id, data}` into the FIFO through a one-entry registered output stage. It sits directly in front of the FIFO's `din`/`wr_en`/`full` pins.

## Interface
- `NREQ`, default 4: number of requesters, 2..16, need not be a power of two.
- `DSIZE`, default 8: data width per requester.
- `IDW`, default `$clog2(NREQ)`: tag width. Derived; do not override.
- `clk` input 1: clock. All logic is rising-edge.
- `rst_b` input 1: reset, asynchronous, active-low.
- `req_valid` input NREQ: per-requester valid.
- `req_data` input NREQ*DSIZE: packed data. Requester i occupies bits `[i*DSIZE +: DSIZE]`.
- `req_last` input NREQ: last beat of a packet. Used only with `FIFO_ARB_LOCK_EN`.
- `req_ready` output NREQ: one-hot (or zero) accept strobe.
- `fifo_din` output IDW+DSIZE: `{id, data}` to the FIFO's `din`.
- `fifo_wr_en` output 1: to the FIFO's `wr_en`.
- `fifo_full` input 1: from the FIFO's `full`.

## Operation
- **State**
  - `ptr` (IDW bits): highest-priority requester.
  - `out_valid`, `out_data` (IDW+DSIZE): output stage.
  - `locked`, `lock_id`: only with the macro.
- **Output-stage accept:** `out_accept = ~out_valid | ~fifo_full`. The stage drains on any edge where `out_valid & ~fifo_full`.
- **Grant selection:** the first i with `req_valid[i]`, scanning `ptr, ptr+1, …, NREQ-1, 0, …, ptr-1`. The index wraps explicitly at NREQ, never at 2^IDW.
- **Ready:** `req_ready[i] = out_accept & (i == grant) & any_valid`. It is combinational from `req_valid`, `fifo_full` and state. It is 0 for every requester while `rst_b` is low.
- **Transfer:** `req_valid[i] & req_ready[i]` on an edge. That edge loads `out_data <= {i, req_data[i]}`, sets `out_valid <= 1`, and sets `ptr <= (i+1) mod NREQ`.
- **No transfer but drain:** `out_valid <= 0`.
- **Stall:** when `out_valid & fifo_full`, `out_data` and `out_valid` hold and `req_ready` is all zero.
- **Outputs:** `fifo_wr_en = out_valid` and `fifo_din = out_data`, both driven directly from registers.
- **Requester rules:**
  - Data must stay stable while valid is high and ready is low.
  - A requester may drop valid without a transfer.
  - Dropping valid does not move `ptr`.
- **Reset values:** `ptr=0`, `out_valid=0`, `out_data=0`, `locked=0`, `fifo_wr_en=0`, `fifo_din=0`, `req_ready=0`.
- **Reset mid-operation:** the beat held in the output stage is discarded. Nothing is written to the FIFO afterwards.

## Timing
- Beat accepted at edge N: `fifo_wr_en=1` with its data during cycle N→N+1. The FIFO captures it at edge N+1 if `fifo_full=0`.
- With the FIFO never full, one beat is transferred every cycle, back to back.
- **Simultaneous drain and accept:** the output stage is refilled on the same edge it empties. There is no bubble.
- **`fifo_full` rising while `out_valid`:** the beat is held. It is written on the first cycle `fifo_full` is low.
- **Fairness:** with all NREQ requesters continuously valid, grants go 0,1,…,NREQ-1,0,… in strict rotation.

## Configuration
- **`FIFO_ARB_LOCK_EN` defined:** packet lock.
  - On a transfer from i with `req_last[i]=0`: `locked <= 1`, `lock_id <= i`.
  - While locked, grant is forced to `lock_id`. Other requesters see `req_ready=0` even if `lock_id` is not valid.
  - A transfer with `req_last[lock_id]=1` clears `locked`.
  - `ptr` advances only on the last beat.
- **Undefined:** arbitration is per beat, `req_last` is ignored, and no lock state is built.

## Structure
- Package `fifo_arb_pkg` holds:
  - function `id_width(nreq)` (clog2 with a minimum of 1);
  - typedef `fifo_arb_state_e` (`IDLE`, `LOCKED`) for the lock variant;
  - localparam `MAX_NREQ = 16`.
- Sub-module `rr_pick`: combinational rotate, find-first, rotate-back picker.
  - Inputs: `req[NREQ]`, `ptr`.
  - Outputs: `grant_id`, `any`.
  - It is reused by future read-side schedulers.
- The top level holds the output stage, `ptr`, and the lock FSM.

## Test plan
- **Back-to-back rotation:** NREQ=4, all valid continuously, FIFO never full → grants 0,1,2,3,0 on consecutive cycles; `fifo_din` id field follows the same order one cycle later.
- **Single requester:** only req 2 valid, data 0xA5 → `req_ready=4'b0100` on the same cycle; `fifo_din={2'd2, 8'hA5}` and `fifo_wr_en=1` next cycle; `ptr=3`.
- **Full stall:** `fifo_full=1` for 3 cycles while `out_valid` → `fifo_din` stable, `req_ready=0`; when full drops, the held beat is written and a new beat is accepted on the same edge.
- **Non-power-of-two wrap:** NREQ=3, ptr=2, req 2 granted → ptr becomes 0, not 3; the next grant with all valid is 0.
- **Reset mid-stall:** assert `rst_b` low with `out_valid=1`, full=1 → `fifo_wr_en`, `req_ready`, `ptr` all 0 immediately; no write after release.
- **`FIFO_ARB_LOCK_EN`:** req 1 sends 3 beats (`last` on the 3rd) with req 0 valid throughout → three consecutive grants to 1, then grant to 2 if valid, else 0.
